// File: rtl/temp_entry_ctrl.sv
// temp_entry_ctrl: debounced three-digit BCD setpoint entry with clamp, valid/ack handoff and idle abort.
module temp_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_TEMP        = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic [3:0] digit_in,
    output logic [3:0] cur_digit,
    output logic [2:0] state,
    output logic [3:0] digit_ones,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_huns,
    output logic [9:0] setpoint,
    output logic       setpoint_valid,
    input  logic       setpoint_ack,
    output logic       busy,
    output logic       aborted
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {ONES = 3'd0, TENS = 3'd1, HUNS = 3'd2, CALC = 3'd3, HOLD = 3'd4} state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, press_q, press_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d, huns_q, huns_d;
    logic [9:0]    setpoint_q, setpoint_d, sum;
    logic          valid_q, valid_d, aborted_q, aborted_d;

    assign cur_digit      = (digit_in > 4'd9) ? 4'd9 : digit_in;
    assign state          = state_q;
    assign digit_ones     = ones_q;
    assign digit_tens     = tens_q;
    assign digit_huns     = huns_q;
    assign setpoint       = setpoint_q;
    assign setpoint_valid = valid_q;
    assign aborted        = aborted_q;
    assign busy           = (state_q == TENS) || (state_q == HUNS) || (state_q == CALC) || (state_q == HOLD);
    assign sum            = 10'(huns_q) * 10'd100 + 10'(tens_q) * 10'd10 + 10'(ones_q);

    always_comb begin
        s1_d       = key_n;
        s2_d       = s1_q;
        deb_d      = deb_q;
        dcnt_d     = '0;
        press_d    = 1'b0;
        state_d    = state_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        huns_d     = huns_q;
        setpoint_d = setpoint_q;
        valid_d    = valid_q;
        aborted_d  = 1'b0;
        idle_d     = '0;
        // Only a press edge (1->0 of the debounced level) produces a pulse.
        if (s2_q != deb_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d   = s2_q;
                press_d = !s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
        case (state_q)
            ONES: if (press_q) begin
                ones_d  = cur_digit;
                state_d = TENS;
            end
            TENS, HUNS: begin
                if (press_q) begin
                    if (state_q == TENS) tens_d = cur_digit;
                    else huns_d = cur_digit;
                    state_d = (state_q == TENS) ? HUNS : CALC;
                end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ONES;
                    ones_d    = '0;
                    tens_d    = '0;
                    huns_d    = '0;
                    aborted_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CALC: begin
                setpoint_d = (sum > 10'(MAX_TEMP)) ? 10'(MAX_TEMP) : sum;
                valid_d    = 1'b1;
                state_d    = HOLD;
            end
            HOLD: if (setpoint_ack) begin
                valid_d = 1'b0;
                state_d = ONES;
            end
            default: state_d = ONES;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            deb_q      <= 1'b1;
            press_q    <= 1'b0;
            dcnt_q     <= '0;
            idle_q     <= '0;
            state_q    <= ONES;
            ones_q     <= '0;
            tens_q     <= '0;
            huns_q     <= '0;
            setpoint_q <= '0;
            valid_q    <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            press_q    <= press_d;
            dcnt_q     <= dcnt_d;
            idle_q     <= idle_d;
            state_q    <= state_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            huns_q     <= huns_d;
            setpoint_q <= setpoint_d;
            valid_q    <= valid_d;
            aborted_q  <= aborted_d;
        end
    end
endmodule
